phase_accumulator_18: RTL

//  NCO phase register stage for one synth voice. Drives the operands of the shared 18-bit

---
 rtl/phase_accumulator_18.sv | 136 +++++++++++++
 1 files changed

// File: rtl/phase_accumulator_18.sv
// NCO phase register for one synth voice: drives the shared 18-bit adder and registers
// its sum once per sample tick, with a gate FSM that lets a released note finish at a wrap.
module phase_accumulator_18 #(
  parameter int unsigned TICK_DIV = 1042,
  parameter int unsigned SAW_BITS = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                note_on,
  input  logic [17:0]         tune_word,
  input  logic                tune_valid,
  output logic                tune_ready,
  output logic [17:0]         add_a,
  output logic [17:0]         add_b,
  output logic                add_cin,
  input  logic [17:0]         add_sum,
  input  logic                add_cout,
  output logic [17:0]         phase,
  output logic [SAW_BITS-1:0] saw,
  output logic                square,
  output logic                wrap,
  output logic                sample_strobe,
  output logic                active
);

  localparam int unsigned PW = 18;
  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [PW-1:0] inc_q, inc_d;
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic          wrap_q, wrap_d;
  logic          strobe_q, strobe_d;
  logic          tick;

  assign tick = (tick_cnt_q == CW'(TICK_DIV - 1));

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      inc_q      <= '0;
      tick_cnt_q <= '0;
      wrap_q     <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      inc_q      <= inc_d;
      tick_cnt_q <= tick_cnt_d;
      wrap_q     <= wrap_d;
      strobe_q   <= strobe_d;
    end
  end

  // Next-state: tick divider, tune handshake and gate FSM
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    inc_d      = inc_q;
    wrap_d     = 1'b0;
    strobe_d   = 1'b0;
    tick_cnt_d = tick ? '0 : tick_cnt_q + CW'(1);

    if (tune_valid && !tick) begin
      inc_d = tune_word;
    end

    unique case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (note_on) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (tick) begin
          phase_d  = add_sum;
          wrap_d   = add_cout;
          strobe_d = 1'b1;
        end
        if (!note_on) begin
          state_d = ST_STOPPING;
        end
      end
      ST_STOPPING: begin
        if (note_on) begin
          state_d = ST_RUN;
          if (tick) begin
            phase_d  = add_sum;
            wrap_d   = add_cout;
            strobe_d = 1'b1;
          end
        end else if (inc_q == '0) begin
          // A zero increment can never reach a wrap, so stop immediately
          state_d  = ST_IDLE;
          phase_d  = '0;
          strobe_d = tick;
        end else if (tick) begin
          strobe_d = 1'b1;
          if (add_cout) begin
            state_d = ST_IDLE;
            phase_d = '0;
            wrap_d  = 1'b1;
          end else begin
            phase_d = add_sum;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase
  end

  assign tune_ready    = !tick;
  assign add_a         = phase_q;
  assign add_b         = inc_q;
  assign add_cin       = 1'b0;
  assign phase         = phase_q;
  assign saw           = phase_q[PW-1 -: SAW_BITS];
  assign square        = phase_q[PW-1];
  assign wrap          = wrap_q;
  assign sample_strobe = strobe_q;
  assign active        = (state_q != ST_IDLE);

endmodule
